// File: rtl/uart_tx_controller.sv
// uart_tx_controller: framed UART transmitter with per-frame latched format and baud divider.
// Define UART_TX_PARITY_EN to insert a parity bit between the data and stop bits.
module uart_tx_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  txValid,
    output logic                  txReady,
    input  logic [DATA_WIDTH-1:0] txData,
    input  logic [3:0]            dataBits,
    input  logic                  parityType,
    input  logic [1:0]            stopBits,
    input  logic [4:0]            overSampling,
    input  logic [DIV_WIDTH-1:0]  baudDivisor,
    output logic                  tx,
    output logic                  busy,
    output logic                  frameDone
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_nxt;
    logic                  ready_en;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [3:0]            nbits_q;
    logic                  two_stop_q;
    logic                  os13_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [4:0]            samp_cnt;
    logic [3:0]            bit_cnt;
    logic                  xfer;
    logic                  tick;
    logic                  bit_end;
    logic                  last_bit;
`ifdef UART_TX_PARITY_EN
    logic                  par_q;
    logic                  par_type_q;
`else
    logic                  parity_unused;
    assign parity_unused = parityType;
`endif
    assign xfer     = txValid && txReady;
    assign txReady  = (state == IDLE) && ready_en;
    assign busy     = state != IDLE;
    assign tick     = div_cnt == div_q - DIV_WIDTH'(1);
    assign bit_end  = tick && (samp_cnt == (os13_q ? 5'd12 : 5'd15));
    // DATA counts data bits; STOP reuses the same counter for stop bits
    assign last_bit = (state == DATA) ? (bit_cnt == nbits_q - 4'd1)
                                      : (bit_cnt == {3'b000, two_stop_q});
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        tx        = 1'b1;
        case (state)
            IDLE:   state_nxt = xfer ? START : IDLE;
            START: begin
                tx        = 1'b0;
                state_nxt = bit_end ? DATA : START;
            end
            DATA: begin
                tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
                state_nxt = (bit_end && last_bit) ? PARITY : DATA;
`else
                state_nxt = (bit_end && last_bit) ? STOP : DATA;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx        = par_q ^ par_type_q;
                state_nxt = bit_end ? STOP : PARITY;
            end
`endif
            STOP:   state_nxt = (bit_end && last_bit) ? IDLE : STOP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en   <= 1'b0;
            frameDone  <= 1'b0;
            shift_q    <= '0;
            nbits_q    <= '0;
            two_stop_q <= 1'b0;
            os13_q     <= 1'b0;
            div_q      <= '0;
            div_cnt    <= '0;
            samp_cnt   <= '0;
            bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
            par_type_q <= 1'b0;
`endif
        end else begin
            ready_en  <= 1'b1;
            frameDone <= (state == STOP) && bit_end && last_bit;
            if (xfer) begin
                // illegal formats collapse to 8 data bits, 1 stop bit, x16, divisor 1
                shift_q    <= txData;
                nbits_q    <= (dataBits >= 4'd5 && dataBits <= 4'd8) ? dataBits : 4'd8;
                two_stop_q <= stopBits == 2'd2;
                os13_q     <= overSampling == 5'd13;
                div_q      <= (baudDivisor == '0) ? DIV_WIDTH'(1) : baudDivisor;
                div_cnt    <= '0;
                samp_cnt   <= '0;
                bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
                par_q      <= 1'b0;
                par_type_q <= parityType;
`endif
            end else if (busy) begin
                div_cnt <= tick ? '0 : div_cnt + DIV_WIDTH'(1);
                if (tick) begin
                    samp_cnt <= bit_end ? 5'd0 : samp_cnt + 5'd1;
                end
                if (bit_end) begin
                    bit_cnt <= (state == START || state == PARITY || last_bit) ? 4'd0 : bit_cnt + 4'd1;
                    if (state == DATA) begin
                        shift_q <= shift_q >> 1;
`ifdef UART_TX_PARITY_EN
                        par_q   <= par_q ^ shift_q[0];
`endif
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_controller.sv
// tb_uart_tx_controller: directed frame-by-frame checks of the UART transmitter.
module tb_uart_tx_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        txValid = 1'b0;
    logic [7:0]  txData = 8'h00;
    logic [3:0]  dataBits = 4'd8;
    logic        parityType = 1'b0;
    logic [1:0]  stopBits = 2'd1;
    logic [4:0]  overSampling = 5'd16;
    logic [15:0] baudDivisor = 16'd1;
    logic        txReady;
    logic        tx;
    logic        busy;
    logic        frameDone;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    uart_tx_controller #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .txValid(txValid), .txReady(txReady),
        .txData(txData), .dataBits(dataBits), .parityType(parityType),
        .stopBits(stopBits), .overSampling(overSampling), .baudDivisor(baudDivisor),
        .tx(tx), .busy(busy), .frameDone(frameDone)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // tx must stay at lvl for n clocks while the frame is in progress
    task automatic hold(input string tag, input logic lvl, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (tx !== lvl || busy !== 1'b1 || txReady !== 1'b0 || frameDone !== 1'b0) bad++;
            @(negedge clk);
        end
        chk({tag, "_bad_clocks"}, bad, 0);
    endtask

    task automatic start_frame(input string tag, input logic [7:0] d, input logic [3:0] nb,
                               input logic pt, input logic [1:0] sb, input logic [4:0] os,
                               input logic [15:0] dv, input logic keep);
        int n = 0;
        txData = d; dataBits = nb; parityType = pt; stopBits = sb;
        overSampling = os; baudDivisor = dv; txValid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 10);
        chk({tag, "_xfer"}, busy, 1);
        if (!keep) begin
            txValid = 1'b0; txData = ~d; dataBits = 4'd6; parityType = ~pt;
            stopBits = 2'd2; overSampling = 5'd13; baudDivisor = 16'd3;
        end
    endtask

    task automatic frame_head(input string tag, input logic [7:0] d, input int nb, input int bl);
        hold({tag, "_start"}, 1'b0, bl);
        for (int i = 0; i < nb; i++) hold($sformatf("%s_d%0d", tag, i), d[i], bl);
    endtask

    task automatic frame_tail(input string tag, input int ns, input int bl);
        hold({tag, "_stop"}, 1'b1, ns * bl);
        chk({tag, "_done"}, frameDone, 1);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_ready"}, txReady, 1);
        chk({tag, "_idle_tx"}, tx, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_ready", txReady, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frameDone, 0);
        reset = 1'b0;
        #1 chk("rst_ready_pre_edge", txReady, 0);
        @(negedge clk);
        chk("ready_after_reset", txReady, 1);

        // 8N1, x16, divisor 1, 0xA5
        start_frame("t1", 8'hA5, 4'd8, 1'b0, 2'd1, 5'd16, 16'd1, 1'b0);
        frame_head("t1", 8'hA5, 8, 16);
`ifdef UART_TX_PARITY_EN
        hold("t1_par", 1'b0, 16);
`endif
        frame_tail("t1", 1, 16);
        @(negedge clk);
        chk("t1_done_one_cycle", frameDone, 0);

        // 5 data bits, 2 stop bits, x13, divisor 4 -> 52-clock bits
        start_frame("t2", 8'h16, 4'd5, 1'b0, 2'd2, 5'd13, 16'd4, 1'b0);
        frame_head("t2", 8'h16, 5, 52);
`ifdef UART_TX_PARITY_EN
        hold("t2_par", 1'b1, 52);
`endif
        frame_tail("t2", 2, 52);

        // 7 data bits of 0x03, even then odd parity
        start_frame("t3", 8'h03, 4'd7, 1'b0, 2'd1, 5'd16, 16'd1, 1'b0);
        frame_head("t3", 8'h03, 7, 16);
`ifdef UART_TX_PARITY_EN
        hold("t3_par_even", 1'b0, 16);
`endif
        frame_tail("t3", 1, 16);
        start_frame("t4", 8'h03, 4'd7, 1'b1, 2'd1, 5'd16, 16'd1, 1'b0);
        frame_head("t4", 8'h03, 7, 16);
`ifdef UART_TX_PARITY_EN
        hold("t4_par_odd", 1'b1, 16);
`endif
        frame_tail("t4", 1, 16);

        // txValid held across three frames: one idle cycle between each
        start_frame("t5a", 8'h15, 4'd5, 1'b0, 2'd1, 5'd16, 16'd1, 1'b1);
        txData = 8'h0A;
        frame_head("t5a", 8'h15, 5, 16);
`ifdef UART_TX_PARITY_EN
        hold("t5a_par", 1'b1, 16);
`endif
        frame_tail("t5a", 1, 16);
        @(negedge clk);
        txData = 8'h1F;
        frame_head("t5b", 8'h0A, 5, 16);
`ifdef UART_TX_PARITY_EN
        hold("t5b_par", 1'b0, 16);
`endif
        frame_tail("t5b", 1, 16);
        @(negedge clk);
        txValid = 1'b0;
        frame_head("t5c", 8'h1F, 5, 16);
`ifdef UART_TX_PARITY_EN
        hold("t5c_par", 1'b1, 16);
`endif
        frame_tail("t5c", 1, 16);
        @(negedge clk);
        chk("t5_stays_idle", busy, 0);

        // reset in the middle of DATA aborts the frame
        start_frame("t6", 8'h00, 4'd8, 1'b0, 2'd1, 5'd16, 16'd1, 1'b0);
        hold("t6_start", 1'b0, 16);
        hold("t6_data", 1'b0, 20);
        #2 reset = 1'b1;
        #1 chk("t6_async_tx", tx, 1);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_done", frameDone, 0);
        chk("t6_async_ready", txReady, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_no_done", frameDone, 0);
        chk("t6_idle_tx", tx, 1);
        start_frame("t6b", 8'h5A, 4'd8, 1'b0, 2'd1, 5'd16, 16'd1, 1'b0);
        frame_head("t6b", 8'h5A, 8, 16);
`ifdef UART_TX_PARITY_EN
        hold("t6b_par", 1'b0, 16);
`endif
        frame_tail("t6b", 1, 16);

        // illegal format collapses to 8N1, x16, divisor 1
        start_frame("t7", 8'hC3, 4'd3, 1'b0, 2'd0, 5'd20, 16'd0, 1'b0);
        frame_head("t7", 8'hC3, 8, 16);
`ifdef UART_TX_PARITY_EN
        hold("t7_par", 1'b0, 16);
`endif
        frame_tail("t7", 1, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_controller.md
UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of txData and maximum data bits per frame.
REQ-002 Parameter: DIV_WIDTH, 16, width of baudDivisor.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 txValid  input  1  requester offers a byte.
REQ-006 txReady  output  1  controller can accept a byte.
REQ-007 txData  input  DATA_WIDTH  byte to send, LSB first.
REQ-008 dataBits  input  4  data bits per frame, legal 5..8.
REQ-009 parityType  input  1  0 = even, 1 = odd.
REQ-010 stopBits  input  2  stop bits, legal 1 or 2.
REQ-011 overSampling  input  5  ticks per bit, legal 16 or 13.
REQ-012 baudDivisor  input  DIV_WIDTH  clocks per oversampling tick.
REQ-013 tx  output  1  serial line, idle high.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 frameDone  output  1  one-cycle pulse at end of frame.

Function
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 txReady SHALL equal 1 exactly in IDLE; a transfer occurs on a cycle with txValid && txReady.
REQ-018 On transfer, txData, dataBits, parityType, stopBits, overSampling and baudDivisor SHALL be latched, and input changes SHALL be ignored until the next transfer.
REQ-019 On transfer, the state SHALL move to START on the next edge, and tx SHALL go low in that cycle.
REQ-020 The divider SHALL count 0..baudDivisor-1 and issue a tick on the terminal count; it SHALL clear on transfer; baudDivisor 0 SHALL behave as 1.
REQ-021 A bit period SHALL end on the tick where the sample counter equals overSampling-1; each bit SHALL last exactly overSampling*divisor clocks.
REQ-022 Illegal latched values SHALL map as follows: dataBits outside 5..8 -> 8; stopBits 0 or 3 -> 1; overSampling other than 13 -> 16.
REQ-023 DATA SHALL shift out bits 0..dataBits-1, LSB first; the bit counter SHALL clear on entry to DATA.
REQ-024 PARITY SHALL drive the XOR of the sent data bits for even parity, and its inverse for odd parity.
REQ-025 STOP SHALL drive tx high for stopBits bit periods.
REQ-026 At the end of the last stop bit, the controller SHALL pulse frameDone, enter IDLE, and assert txReady in the following cycle.
REQ-027 The minimum gap between frames SHALL be one clk of idle-high tx, even when txValid is held continuously.
REQ-028 Frame length from START to IDLE SHALL be (1+dataBits+P+stopBits)*overSampling*divisor clocks, where P=1 when parity is enabled and 0 otherwise.

Reset
REQ-029 While reset is high, the controller SHALL be in IDLE with tx=1, txReady=0, busy=0, frameDone=0, and all counters and latches at 0.
REQ-030 After reset deasserts, txReady SHALL be 1 from the first clk edge.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately, with tx high asynchronously and no frameDone pulse.

Configuration
REQ-032 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL be inserted between DATA and STOP.
REQ-033 Without UART_TX_PARITY_EN, DATA SHALL go directly to STOP, parityType SHALL be ignored, and P=0.

Verification
REQ-034 8 data bits, 1 stop bit, divisor 1, oversampling 16, no parity, txData=8'hA5 -> tx low 16 clocks, then 1,0,1,0,0,1,0,1 at 16 clocks each, then high 16 clocks; frameDone pulses at clock 160 after START.
REQ-035 UART_TX_PARITY_EN defined, even parity, 7 data bits, txData=8'h03 -> parity bit 0; with odd parity -> parity bit 1; frame is 10 bit periods.
REQ-036 2 stop bits, oversampling 13, divisor 4, 5 data bits -> each bit is 52 clocks; stop phase is 104 clocks high.
REQ-037 txValid held high over three bytes -> exactly one idle-high cycle between frames; txReady high only in those cycles.
REQ-038 Reset pulsed in the middle of DATA -> tx high, busy 0 and no frameDone; the next transfer sends a clean frame.
REQ-039 Illegal inputs (dataBits=3, stopBits=0, overSampling=20, divisor 0) -> frame behaves as 8 data bits, 1 stop bit, oversampling 16, divisor 1.
